// File: rtl/lfsr_pkg.sv
// Shared types and default constants for the LFSR generator.
package lfsr_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RUN     = 2'd1,
        RECOVER = 2'd2
    } lfsr_state_e;

    localparam int                         LFSR_DEF_WIDTH = 6;
    localparam logic [LFSR_DEF_WIDTH-1:0]  LFSR_DEF_TAPS  = 6'b110000;
    localparam logic [LFSR_DEF_WIDTH-1:0]  LFSR_DEF_SEED  = 6'd1;

endpackage

// File: rtl/lfsr_gen_if.sv
// Control and status bundle for lfsr_gen; master drives controls, slave is the generator.
interface lfsr_gen_if import lfsr_pkg::*; #(
    parameter int WIDTH = LFSR_DEF_WIDTH
);
    logic             start;
    logic             stop;
    logic             load;
    logic [WIDTH-1:0] seed_in;
    logic             clr_lock;
    logic [WIDTH-1:0] state_q;
    logic             bit_out;
    logic             running;
    logic             wrap;
    logic [WIDTH-1:0] period_q;
    logic             lockup;

    modport master (
        output start, stop, load, seed_in, clr_lock,
        input  state_q, bit_out, running, wrap, period_q, lockup
    );

    modport slave (
        input  start, stop, load, seed_in, clr_lock,
        output state_q, bit_out, running, wrap, period_q, lockup
    );
endinterface

// File: rtl/lfsr_next.sv
// Combinational one-step LFSR advance, Fibonacci or Galois form; zero latency, no flow control.
module lfsr_next import lfsr_pkg::*; #(
    parameter int               WIDTH  = LFSR_DEF_WIDTH,
    parameter logic [WIDTH-1:0] TAPS   = WIDTH'(LFSR_DEF_TAPS),
    parameter bit               GALOIS = 1'b0
) (
    input  logic [WIDTH-1:0] cur_i,
    output logic [WIDTH-1:0] nxt_o
);

    generate
        if (GALOIS) begin : g_galois
            // MSB rotates into bit 0 and is XORed into every tapped position above it.
            assign nxt_o = {cur_i[WIDTH-2:0], cur_i[WIDTH-1]}
                         ^ ({TAPS[WIDTH-2:0], 1'b0} & {WIDTH{cur_i[WIDTH-1]}});
        end else begin : g_fib
            assign nxt_o = {cur_i[WIDTH-2:0], ^(cur_i & TAPS)};
        end
    endgenerate

endmodule

// File: rtl/lfsr_gen.sv
// LFSR generator with run/stop FSM, period counter, wrap pulse and all-zero lockup recovery.
// One step per cycle in RUN; all outputs registered except bit_out/running decodes.
module lfsr_gen import lfsr_pkg::*; #(
    parameter int               WIDTH  = LFSR_DEF_WIDTH,
    parameter logic [WIDTH-1:0] TAPS   = WIDTH'(LFSR_DEF_TAPS),
    parameter logic [WIDTH-1:0] SEED   = WIDTH'(LFSR_DEF_SEED),
    parameter bit               GALOIS = 1'b0
) (
    input  logic      clk,
    input  logic      reset_n,
    lfsr_gen_if.slave bus
);

    lfsr_state_e      fsm_q;
    logic [WIDTH-1:0] lfsr_q, lfsr_d;
    logic [WIDTH-1:0] start_val_q, start_val_d;
    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] prd_q, prd_d;
    logic             wrap_q, wrap_d;
    logic             lockup_q;
    logic [WIDTH-1:0] step_val;
    logic [WIDTH-1:0] cnt_inc;
    logic             zero_evt;

    lfsr_next #(
        .WIDTH  (WIDTH),
        .TAPS   (TAPS),
        .GALOIS (GALOIS)
    ) u_next (
        .cur_i (lfsr_q),
        .nxt_o (step_val)
    );

    assign cnt_inc = (&cnt_q) ? cnt_q : cnt_q + WIDTH'(1);

    always_comb begin
        lfsr_d      = lfsr_q;
        start_val_d = start_val_q;
        cnt_d       = cnt_q;
        prd_d       = prd_q;
        wrap_d      = 1'b0;
        if (bus.load) begin
            lfsr_d      = bus.seed_in;
            start_val_d = bus.seed_in;
            cnt_d       = '0;
        end else if (fsm_q == RUN) begin
            lfsr_d = step_val;
            if (step_val == start_val_q) begin
                wrap_d = 1'b1;
                prd_d  = cnt_inc;
                cnt_d  = '0;
            end else begin
                cnt_d = cnt_inc;
            end
        end
        // Whatever produced an all-zero candidate, reseed instead of storing it.
        zero_evt = (lfsr_d == '0);
        if (zero_evt) begin
            lfsr_d      = SEED;
            start_val_d = SEED;
            cnt_d       = '0;
            wrap_d      = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            fsm_q       <= IDLE;
            lfsr_q      <= SEED;
            start_val_q <= SEED;
            cnt_q       <= '0;
            prd_q       <= '0;
            wrap_q      <= 1'b0;
            lockup_q    <= 1'b0;
        end else begin
            lfsr_q      <= lfsr_d;
            start_val_q <= start_val_d;
            cnt_q       <= cnt_d;
            prd_q       <= prd_d;
            wrap_q      <= wrap_d;
            if (zero_evt) begin
                fsm_q <= RECOVER;
            end else begin
                case (fsm_q)
                    IDLE:    if (bus.start && !bus.stop) fsm_q <= RUN;
                    RUN:     if (bus.stop) fsm_q <= IDLE;
                    RECOVER: fsm_q <= RUN;
                    default: fsm_q <= IDLE;
                endcase
            end
            if (zero_evt) begin
                lockup_q <= 1'b1;
            end else if (bus.clr_lock) begin
                lockup_q <= 1'b0;
            end
        end
    end

    assign bus.state_q  = lfsr_q;
    assign bus.bit_out  = lfsr_q[WIDTH-1];
    assign bus.running  = (fsm_q == RUN);
    assign bus.wrap     = wrap_q;
    assign bus.period_q = prd_q;
    assign bus.lockup   = lockup_q;

endmodule

// File: tb/tb_lfsr_gen.sv
// Directed bench for lfsr_gen: one Fibonacci and one Galois instance with default taps.
module tb_lfsr_gen;

    logic clk     = 1'b0;
    logic reset_n = 1'b1;
    int   checks  = 0;
    int   errors  = 0;

    lfsr_gen_if #(.WIDTH(6)) bf();
    lfsr_gen_if #(.WIDTH(6)) bg();

    lfsr_gen #(.WIDTH(6), .TAPS(6'b110000), .SEED(6'd1), .GALOIS(1'b0)) dut_f (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bf)
    );

    lfsr_gen #(.WIDTH(6), .TAPS(6'b110000), .SEED(6'd1), .GALOIS(1'b1)) dut_g (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bg)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        #2 reset_n = 1'b0;
        #1;
        checks++; if (bf.state_q !== 6'd1) begin errors++; $display("FAIL reset_state got %0h want 1", bf.state_q); end
        checks++; if (bf.running !== 1'b0) begin errors++; $display("FAIL reset_running got %0b want 0", bf.running); end
        checks++; if (bf.wrap !== 1'b0) begin errors++; $display("FAIL reset_wrap got %0b want 0", bf.wrap); end
        checks++; if (bf.period_q !== 6'd0) begin errors++; $display("FAIL reset_period got %0d want 0", bf.period_q); end
        checks++; if (bf.lockup !== 1'b0) begin errors++; $display("FAIL reset_lockup got %0b want 0", bf.lockup); end
        checks++; if (bf.bit_out !== 1'b0) begin errors++; $display("FAIL reset_bit_out got %0b want 0", bf.bit_out); end
        checks++; if (bg.state_q !== 6'd1) begin errors++; $display("FAIL reset_galois_state got %0h want 1", bg.state_q); end
        tick();
        tick();
        reset_n = 1'b1;
        tick();
        checks++; if (bf.running !== 1'b0 || bf.state_q !== 6'd1) begin errors++; $display("FAIL idle_hold got run=%0b st=%0h want run=0 st=1", bf.running, bf.state_q); end
    endtask

    task automatic test_fib_steps;
        logic [5:0] exp;
        bf.start = 1'b1;
        tick();
        bf.start = 1'b0;
        checks++; if (bf.running !== 1'b1 || bf.state_q !== 6'd1) begin errors++; $display("FAIL start got run=%0b st=%0h want run=1 st=1", bf.running, bf.state_q); end
        for (int i = 1; i <= 4; i++) begin
            tick();
            exp = 6'd1 << i;
            checks++; if (bf.state_q !== exp || bf.bit_out !== 1'b0) begin errors++; $display("FAIL fib_step%0d got st=%0h bit=%0b want st=%0h bit=0", i, bf.state_q, bf.bit_out, exp); end
        end
        tick();
        checks++; if (bf.state_q !== 6'b100001) begin errors++; $display("FAIL fib_step5 got %0h want 21", bf.state_q); end
        checks++; if (bf.bit_out !== 1'b1) begin errors++; $display("FAIL fib_bit5 got %0b want 1", bf.bit_out); end
    endtask

    task automatic test_wrap;
        int n;
        bit seen;
        n = 5;
        seen = 1'b0;
        for (int k = 0; k < 200 && !seen; k++) begin
            tick();
            n++;
            if (bf.wrap) seen = 1'b1;
        end
        checks++; if (!seen || n !== 63) begin errors++; $display("FAIL wrap1_steps got seen=%0b n=%0d want seen=1 n=63", seen, n); end
        checks++; if (bf.period_q !== 6'd63 || bf.state_q !== 6'd1) begin errors++; $display("FAIL wrap1_period got p=%0d st=%0h want p=63 st=1", bf.period_q, bf.state_q); end
        tick();
        checks++; if (bf.wrap !== 1'b0) begin errors++; $display("FAIL wrap_pulse got %0b want 0", bf.wrap); end
        n = 1;
        seen = 1'b0;
        for (int k = 0; k < 200 && !seen; k++) begin
            tick();
            n++;
            if (bf.wrap) seen = 1'b1;
        end
        checks++; if (!seen || n !== 63 || bf.period_q !== 6'd63) begin errors++; $display("FAIL wrap2 got seen=%0b n=%0d p=%0d want 1/63/63", seen, n, bf.period_q); end
    endtask

    task automatic test_stop;
        bf.stop = 1'b1;
        tick();
        bf.stop = 1'b0;
        checks++; if (bf.running !== 1'b0 || bf.state_q !== 6'd2) begin errors++; $display("FAIL stop got run=%0b st=%0h want run=0 st=2", bf.running, bf.state_q); end
        tick();
        checks++; if (bf.state_q !== 6'd2) begin errors++; $display("FAIL stop_hold got %0h want 2", bf.state_q); end
    endtask

    task automatic test_galois;
        logic [5:0] exp;
        int n;
        bit seen;
        bg.start = 1'b1;
        tick();
        bg.start = 1'b0;
        checks++; if (bg.running !== 1'b1) begin errors++; $display("FAIL gal_start got %0b want 1", bg.running); end
        for (int i = 1; i <= 5; i++) begin
            tick();
            exp = 6'd1 << i;
            checks++; if (bg.state_q !== exp) begin errors++; $display("FAIL gal_step%0d got %0h want %0h", i, bg.state_q, exp); end
        end
        tick();
        checks++; if (bg.state_q !== 6'b100001) begin errors++; $display("FAIL gal_step6 got %0h want 21", bg.state_q); end
        n = 6;
        seen = 1'b0;
        for (int k = 0; k < 200 && !seen; k++) begin
            tick();
            n++;
            if (bg.wrap) seen = 1'b1;
        end
        checks++; if (!seen || n !== 63 || bg.period_q !== 6'd63) begin errors++; $display("FAIL gal_wrap got seen=%0b n=%0d p=%0d want 1/63/63", seen, n, bg.period_q); end
    endtask

    task automatic test_concurrent;
        int n;
        bit seen;
        bf.start = 1'b1;
        bf.stop  = 1'b1;
        tick();
        bf.stop  = 1'b0;
        checks++; if (bf.running !== 1'b0 || bf.state_q !== 6'd2) begin errors++; $display("FAIL start_stop got run=%0b st=%0h want run=0 st=2", bf.running, bf.state_q); end
        tick();
        bf.start = 1'b0;
        checks++; if (bf.running !== 1'b1 || bf.state_q !== 6'd2) begin errors++; $display("FAIL restart got run=%0b st=%0h want run=1 st=2", bf.running, bf.state_q); end
        tick();
        checks++; if (bf.state_q !== 6'd4) begin errors++; $display("FAIL restep got %0h want 4", bf.state_q); end
        bf.seed_in = 6'h2A;
        bf.load    = 1'b1;
        tick();
        bf.load    = 1'b0;
        checks++; if (bf.state_q !== 6'h2A || bf.running !== 1'b1) begin errors++; $display("FAIL load_run got st=%0h run=%0b want st=2a run=1", bf.state_q, bf.running); end
        tick();
        checks++; if (bf.state_q !== 6'h15) begin errors++; $display("FAIL load_next got %0h want 15", bf.state_q); end
        n = 1;
        seen = 1'b0;
        for (int k = 0; k < 200 && !seen; k++) begin
            tick();
            n++;
            if (bf.wrap) seen = 1'b1;
        end
        checks++; if (!seen || n !== 63 || bf.state_q !== 6'h2A) begin errors++; $display("FAIL load_wrap got seen=%0b n=%0d st=%0h want 1/63/2a", seen, n, bf.state_q); end
    endtask

    task automatic test_lockup;
        bf.seed_in = 6'd0;
        bf.load    = 1'b1;
        tick();
        bf.load    = 1'b0;
        checks++; if (bf.lockup !== 1'b1 || bf.running !== 1'b0 || bf.state_q !== 6'd1) begin errors++; $display("FAIL zero_load got lk=%0b run=%0b st=%0h want 1/0/1", bf.lockup, bf.running, bf.state_q); end
        tick();
        checks++; if (bf.lockup !== 1'b1 || bf.running !== 1'b1 || bf.state_q !== 6'd1) begin errors++; $display("FAIL recover_exit got lk=%0b run=%0b st=%0h want 1/1/1", bf.lockup, bf.running, bf.state_q); end
        tick();
        checks++; if (bf.state_q !== 6'd2) begin errors++; $display("FAIL recover_step got %0h want 2", bf.state_q); end
        bf.clr_lock = 1'b1;
        tick();
        checks++; if (bf.lockup !== 1'b0 || bf.state_q !== 6'd4) begin errors++; $display("FAIL clr_lock got lk=%0b st=%0h want 0/4", bf.lockup, bf.state_q); end
        bf.load = 1'b1;
        tick();
        bf.load = 1'b0;
        checks++; if (bf.lockup !== 1'b1 || bf.running !== 1'b0) begin errors++; $display("FAIL set_beats_clr got lk=%0b run=%0b want 1/0", bf.lockup, bf.running); end
        tick();
        bf.clr_lock = 1'b0;
        checks++; if (bf.lockup !== 1'b0 || bf.running !== 1'b1 || bf.state_q !== 6'd1) begin errors++; $display("FAIL clr_after got lk=%0b run=%0b st=%0h want 0/1/1", bf.lockup, bf.running, bf.state_q); end
    endtask

    task automatic test_reset_midrun;
        for (int i = 0; i < 20; i++) tick();
        checks++; if (bf.running !== 1'b1 || bf.period_q !== 6'd63) begin errors++; $display("FAIL pre_reset got run=%0b p=%0d want 1/63", bf.running, bf.period_q); end
        #2 reset_n = 1'b0;
        bf.start = 1'b1;
        #1;
        checks++; if (bf.state_q !== 6'd1 || bf.running !== 1'b0 || bf.period_q !== 6'd0) begin errors++; $display("FAIL async_reset got st=%0h run=%0b p=%0d want 1/0/0", bf.state_q, bf.running, bf.period_q); end
        tick();
        reset_n = 1'b1;
        tick();
        checks++; if (bf.running !== 1'b1 || bf.state_q !== 6'd1) begin errors++; $display("FAIL release_edge1 got run=%0b st=%0h want 1/1", bf.running, bf.state_q); end
        tick();
        bf.start = 1'b0;
        checks++; if (bf.state_q !== 6'd2) begin errors++; $display("FAIL release_edge2 got %0h want 2", bf.state_q); end
    endtask

    initial begin
        bf.start = 1'b0; bf.stop = 1'b0; bf.load = 1'b0; bf.seed_in = 6'd0; bf.clr_lock = 1'b0;
        bg.start = 1'b0; bg.stop = 1'b0; bg.load = 1'b0; bg.seed_in = 6'd0; bg.clr_lock = 1'b0;
        test_reset();
        test_fib_steps();
        test_wrap();
        test_stop();
        test_galois();
        test_concurrent();
        test_lockup();
        test_reset_midrun();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/lfsr_gen.md
LFSR_GEN -- requirements
Module: lfsr_gen

Interface
REQ-001 Parameter WIDTH, default 6, range 3..32, register length in bits.
REQ-002 Parameter TAPS, default 6'b110000, WIDTH-bit feedback tap mask; TAPS[WIDTH-1] SHALL be 1.
REQ-003 Parameter SEED, default 1, WIDTH-bit reset/recovery value; nonzero.
REQ-004 Parameter GALOIS, default 0; 0 selects Fibonacci, 1 selects Galois.
REQ-005 clk  input  1  sole clock; all state SHALL update on its rising edge.
REQ-006 reset_n  input  1  asynchronous, active-low reset.
REQ-007 start  input  1  begin stepping.
REQ-008 stop  input  1  halt stepping.
REQ-009 load  input  1  load seed_in this cycle.
REQ-010 seed_in  input  WIDTH  runtime seed.
REQ-011 clr_lock  input  1  clear the lockup flag.
REQ-012 state_q  output  WIDTH  current register contents.
REQ-013 bit_out  output  1  equals state_q[WIDTH-1].
REQ-014 running  output  1  high in RUN.
REQ-015 wrap  output  1  one-cycle pulse when the sequence returns to its start value.
REQ-016 period_q  output  WIDTH  step count captured at the last wrap.
REQ-017 lockup  output  1  sticky; high after an all-zero state was detected.

Function
REQ-018 FSM states SHALL be IDLE, RUN and RECOVER.
REQ-019 Transitions:
- IDLE -> RUN on start.
- RUN -> IDLE on stop.
- any state -> RECOVER when the register would hold all-zero.
- RECOVER -> RUN unconditionally after one cycle.
REQ-020 When stop and start are both high, stop SHALL win.
REQ-021 Fibonacci step: next = {state[WIDTH-2:0], fb}, where fb = XOR of state[i] over every i with TAPS[i]=1.
REQ-022 Galois step:
- next[0] = state[WIDTH-1].
- next[i] = state[i-1] ^ (TAPS[i-1] & state[WIDTH-1]), for i = 1..WIDTH-1.
REQ-023 The register SHALL step exactly once per cycle in RUN, and SHALL hold in IDLE and RECOVER.
REQ-024 Load in any state:
- state_q <= seed_in next cycle.
- The start value becomes seed_in.
- The step counter clears.
- FSM state is unchanged.
- Load SHALL take priority over a step in the same cycle.
REQ-025 Load of all-zero seed_in:
- lockup set.
- FSM enters RECOVER.
- state_q <= SEED on the RECOVER cycle.
- The start value becomes SEED.
- The counter clears.
REQ-026 An internally reached all-zero state SHALL be handled as in REQ-025; with a valid primitive TAPS this state is unreachable.
REQ-027 The step counter is WIDTH bits and increments on each step.
REQ-028 wrap and capture: when a step produces next == start value:
- wrap is asserted for the following cycle.
- period_q <= counter+1.
- The counter clears.
REQ-029 The counter SHALL saturate at all-ones rather than wrap to zero.
REQ-030 lockup SHALL clear on clr_lock; if clr_lock coincides with a new lockup event, the set SHALL win.
REQ-031 Outputs SHALL be registered, except bit_out and running, which are direct decodes of registered state.

Reset
REQ-032 reset_n low SHALL asynchronously force:
- state_q = SEED and start value = SEED.
- FSM = IDLE.
- counter = 0, period_q = 0.
- wrap = 0, lockup = 0.
REQ-033 Reset asserted mid-RUN SHALL abort immediately, with no partial step.
REQ-034 Release SHALL be synchronous to clk, with the first possible step on the second rising edge after release.

Structure
REQ-035 A shared package lfsr_pkg SHALL hold:
- the FSM state enum lfsr_state_e;
- the default constants LFSR_DEF_WIDTH, LFSR_DEF_TAPS and LFSR_DEF_SEED.
REQ-036 Next-state logic SHALL be one combinational sub-module, lfsr_next, parametrised by WIDTH, TAPS and GALOIS.
REQ-037 lfsr_gen SHALL contain the FSM, counter, wrap and lockup logic.

Verification
REQ-038 Defaults, reset release, then start:
- bit_out = 0 for steps 1-4.
- state_q = 6'b100001 after step 5.
- bit_out = 1 after step 5.
REQ-039 Defaults, free run: a wrap pulse after 63 steps, with period_q = 63; repeats every 63 cycles.
REQ-040 Galois=1, WIDTH=6, same taps: the wrap period equals 63.
REQ-041 In RUN, load seed_in = 0:
- lockup = 1.
- One RECOVER cycle, with state_q = SEED.
- Running resumes.
- clr_lock then drops lockup.
REQ-042 Concurrent-control cases:
- start and stop together in IDLE -> stays IDLE.
- load and step in the same RUN cycle -> state_q = seed_in.
REQ-043 reset_n low mid-RUN at step 20 -> state_q = SEED, running = 0 and period_q = 0 without waiting for a clock edge.
